// File: rtl/fnd_display_scheduler.sv
// Purpose: shares one 4-digit FND display among N_REQ requesters using round-robin dwell slots, with urgent preemption.
// Latency: outputs are registered, so value_out, grant and blank follow the inputs by one clk edge.
// Backpressure: none. A dropped req or a new urgent request takes effect on the next edge.
// Optional: define FND_SCHED_BLINK_EN to blink the display every BLINK_HALF cycles while in URGENT.
module fnd_display_scheduler #(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 100_000_000
`ifdef FND_SCHED_BLINK_EN
  , parameter int BLINK_HALF = 25_000_000
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     urgent,
  input  logic                 lock,
  input  logic [16*N_REQ-1:0]  value_in,
  output logic [15:0]          value_out,
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           blank,
  output logic                 switch_pulse
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, URGENT} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr, idx_nxt;
  logic              have_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic [DW-1:0]     dwell_cnt, dwell_nxt;
  logic [N_REQ-1:0]  uq;
  logic              u_any;
  logic [IW-1:0]     u_idx;
  logic [IW:0]       nx_req;

  // First set bit of mask strictly after start, wrapping; start itself is the last candidate.
  function automatic logic [IW:0] find_next(input logic [N_REQ-1:0] mask,
                                            input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = start;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(start) + k) % N_REQ;
      if (!found && mask[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign uq     = urgent & req;
  assign u_any  = |uq;
  assign nx_req = find_next(req, rr_ptr);

  // Lowest-index urgent requester.
  always_comb begin
    u_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (uq[i]) u_idx = IW'(i);
    end
  end

  // Next owner and state; rr_ptr doubles as the current owner index whenever grant is nonzero.
  always_comb begin
    state_nxt = state;
    idx_nxt   = rr_ptr;
    have_nxt  = 1'b0;
    dwell_nxt = '0;
    case (state)
      IDLE: begin
        if (u_any) begin
          state_nxt = URGENT;
          idx_nxt   = u_idx;
          have_nxt  = 1'b1;
        end else if (nx_req[IW]) begin
          state_nxt = SHOW;
          idx_nxt   = nx_req[IW-1:0];
          have_nxt  = 1'b1;
        end
      end
      SHOW: begin
        have_nxt = 1'b1;
        if (u_any) begin
          state_nxt = URGENT;
          idx_nxt   = u_idx;
        end else if (!req[rr_ptr]) begin
          if (nx_req[IW]) begin
            idx_nxt = nx_req[IW-1:0];
          end else begin
            state_nxt = IDLE;
            have_nxt  = 1'b0;
          end
        end else if (lock) begin
          dwell_nxt = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          // With no other requester the search wraps back to the owner itself.
          idx_nxt = nx_req[IW-1:0];
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      URGENT: begin
        have_nxt = 1'b1;
        if (uq[rr_ptr]) begin
          state_nxt = URGENT;
        end else if (u_any) begin
          idx_nxt = u_idx;
        end else if (nx_req[IW]) begin
          state_nxt = SHOW;
          idx_nxt   = nx_req[IW-1:0];
        end else begin
          state_nxt = IDLE;
          have_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_nxt = have_nxt ? (N_REQ'(1) << idx_nxt) : '0;

  // State, owner and data registers; value_out tracks the owner's slice live.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= IW'(N_REQ - 1);
      dwell_cnt    <= '0;
      grant        <= '0;
      switch_pulse <= 1'b0;
      value_out    <= 16'h0000;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= idx_nxt;
      dwell_cnt    <= dwell_nxt;
      grant        <= grant_nxt;
      switch_pulse <= have_nxt && (grant_nxt != grant);
      value_out    <= have_nxt ? value_in[16*int'(idx_nxt) +: 16] : 16'h0000;
    end
  end

`ifdef FND_SCHED_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  logic [BW-1:0] blink_cnt;

  // Blank: dark in IDLE, lit in SHOW, toggling every BLINK_HALF cycles in URGENT (lit on entry).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank     <= 4'hF;
      blink_cnt <= '0;
    end else if (state_nxt == IDLE) begin
      blank     <= 4'hF;
      blink_cnt <= '0;
    end else if (state_nxt == SHOW || state != URGENT || grant_nxt != grant) begin
      blank     <= 4'h0;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blank     <= ~blank;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  // Blank: dark only while nobody owns the display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blank <= 4'hF;
    else          blank <= (state_nxt == IDLE) ? 4'hF : 4'h0;
  end
`endif

endmodule
